cheshire_hyperbus_cfg_seq: RTL

CHESHIRE_HYPERBUS_CFG_SEQ -- requirements
Module: cheshire_hyperbus_cfg_seq

---
 rtl/cheshire_hyperbus_pkg.sv | 27 ++
 rtl/cheshire_hyperbus_cfg_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cheshire_hyperbus_pkg.sv
// Shared types for the HyperBus configuration sequencer: table entry layout
// at default widths, FSM state encoding and index-width helper.
package cheshire_hyperbus_pkg;

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 32;

    // Field order matches the flat per-entry vector {valid, addr, wdata}.
    typedef struct packed {
        logic                    valid;
        logic [DefAddrWidth-1:0] addr;
        logic [DefDataWidth-1:0] wdata;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cheshire_hyperbus_cfg_seq.sv
// Configuration-table sequencer: walks a table of register writes, issuing one
// request at a time, skipping invalid entries and retrying error responses.
// Optional feature macro CHESHIRE_HYPERBUS_CFG_SEQ_READBACK_EN: every good
// write is followed by a read of the same address, checked against wdata.
module cheshire_hyperbus_cfg_seq
    import cheshire_hyperbus_pkg::*;
#(
    parameter  int unsigned NumEntries = 4,
    parameter  int unsigned AddrWidth  = 32,
    parameter  int unsigned DataWidth  = 32,
    parameter  int unsigned MaxRetries = 2,
    localparam int unsigned IdxWidth   = idx_width(NumEntries),
    localparam int unsigned EntryWidth = 1 + AddrWidth + DataWidth
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic [NumEntries-1:0][EntryWidth-1:0] table_i,
    output logic                                 req_valid_o,
    input  logic                                 req_ready_i,
    output logic [AddrWidth-1:0]                 req_addr_o,
    output logic [DataWidth-1:0]                 req_wdata_o,
    output logic                                 req_write_o,
    input  logic                                 rsp_valid_i,
    input  logic                                 rsp_error_i,
    input  logic [DataWidth-1:0]                 rsp_rdata_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic [IdxWidth-1:0]                  idx_o
);

    localparam int unsigned         RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam logic [RetryWidth-1:0] RetryLimit = RetryWidth'(MaxRetries);
    localparam logic [IdxWidth-1:0]   LastIdx    = IdxWidth'(NumEntries - 1);

    if ((NumEntries == 0) || (NumEntries > 64)) begin : g_bad_num_entries
        $error("cheshire_hyperbus_cfg_seq: NumEntries must be within 1..64");
    end

    state_e                  state;
    logic [IdxWidth-1:0]     idx;
    logic [RetryWidth-1:0]   retry;
    logic                    rd_phase;
    logic                    req_write_q;
    logic                    rsp_bad;
    logic                    cur_valid;
    logic [AddrWidth-1:0]    cur_addr;
    logic [DataWidth-1:0]    cur_wdata;

    assign {cur_valid, cur_addr, cur_wdata} = table_i[idx];
    assign idx_o = idx;

`ifdef CHESHIRE_HYPERBUS_CFG_SEQ_READBACK_EN
    localparam bit ReadbackEn = 1'b1;
    // A read-phase response is bad on an error flag or on data not matching the write.
    assign rsp_bad     = rsp_error_i || (rd_phase && (rsp_rdata_i != req_wdata_o));
    assign req_write_o = req_write_q;
`else
    localparam bit ReadbackEn = 1'b0;
    logic unused_readback;
    assign unused_readback = ^{rsp_rdata_i, req_write_q};
    assign rsp_bad         = rsp_error_i;
    assign req_write_o     = 1'b1;
`endif

    // Sequencer FSM with registered request payload and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            idx         <= '0;
            retry       <= '0;
            rd_phase    <= 1'b0;
            req_write_q <= 1'b0;
            req_valid_o <= 1'b0;
            req_addr_o  <= '0;
            req_wdata_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state    <= ISSUE;
                        idx      <= '0;
                        retry    <= '0;
                        rd_phase <= 1'b0;
                        busy_o   <= 1'b1;
                        done_o   <= 1'b0;
                        error_o  <= 1'b0;
                    end
                end
                // req_valid_o low marks the first ISSUE cycle, high the handshake wait.
                ISSUE: begin
                    if (!req_valid_o) begin
                        if (rd_phase) begin
                            req_valid_o <= 1'b1;
                            req_write_q <= 1'b0;
                        end else if (cur_valid) begin
                            req_valid_o <= 1'b1;
                            req_write_q <= 1'b1;
                            req_addr_o  <= cur_addr;
                            req_wdata_o <= cur_wdata;
                        end else if (idx == LastIdx) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (req_ready_i) begin
                        req_valid_o <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid_i) begin
                        if (rsp_bad) begin
                            if (retry != RetryLimit) begin
                                retry    <= retry + 1'b1;
                                rd_phase <= 1'b0;
                                state    <= ISSUE;
                            end else begin
                                state   <= ERR;
                                busy_o  <= 1'b0;
                                error_o <= 1'b1;
                            end
                        end else if (ReadbackEn && !rd_phase) begin
                            rd_phase <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            retry    <= '0;
                            rd_phase <= 1'b0;
                            if (idx == LastIdx) begin
                                state  <= DONE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= ISSUE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
